alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit combinational ALU: same fn3/fn2/kind encoding and the same operand set (rd1, rd2, _const, sc).
- Adds operand width WIDTH, a start/busy/done handshake, and a registered carry flag (cflag) so that fn3=001/011 are true add-with-carry and subtract-with-borrow.
- Shifts and rotates run on an iterative 1-bit-per-cycle shifter.
- Sits between register-file read and write-back; the controller stalls on busy.

---
 rtl/alu_seq.sv | 94 +++++++++
 tb/tb_alu_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake, carry flag and 1-bit-per-cycle shifter
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SCW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       kind,
    input  logic [2:0]       fn3,
    input  logic [1:0]       fn2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] _const,
    input  logic [SCW-1:0]   sc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Wdata,
    output logic             store_ex,
    output logic             cflag
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
    state_t           state;
    logic [3:0]       k_r;
    logic [2:0]       f3_r;
    logic [1:0]       f2_r;
    logic [WIDTH-1:0] a_r, b_r, lg, sh_val;
    logic [SCW-1:0]   cnt_r;
    logic             cin_r, valid, sh_out;
    logic [WIDTH:0]   ea, eb, ci, arith, res;
    assign ea = {1'b0, a_r};
    assign eb = {1'b0, b_r};
    assign ci = {{WIDTH{1'b0}}, f3_r[0] & cin_r};
    // bit WIDTH of the extended difference is the borrow
    assign arith = f3_r[1] ? ea - eb - ci : ea + eb + ci;
    assign lg = f3_r[1:0] == 2'b00 ? a_r & b_r :
                f3_r[1:0] == 2'b01 ? a_r | b_r :
                f3_r[1:0] == 2'b10 ? a_r ^ b_r : ~(a_r & b_r);
    assign valid = k_r == 4'b0000 || k_r == 4'b0001 || k_r == 4'b0010;
    assign res = !valid ? '0 :
                 k_r == 4'b0010 ? {1'b0, a_r} :
                 f3_r[2] ? {1'b0, lg} : arith;
    assign sh_val = f2_r == 2'b00 ? {a_r[WIDTH-2:0], 1'b0} :
                    f2_r == 2'b01 ? {1'b0, a_r[WIDTH-1:1]} :
                    f2_r == 2'b10 ? {a_r[WIDTH-2:0], a_r[WIDTH-1]} : {a_r[0], a_r[WIDTH-1:1]};
    assign sh_out = f2_r[0] ? a_r[0] : a_r[WIDTH-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Wdata    <= '0;
            store_ex <= 1'b0;
            cflag    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k_r   <= kind;
                    f3_r  <= fn3;
                    f2_r  <= fn2;
                    a_r   <= rd1;
                    b_r   <= kind == 4'b0001 ? _const : rd2;
                    cnt_r <= sc;
                    cin_r <= cflag;
                    busy  <= 1'b1;
                    state <= (kind == 4'b0010 && sc != '0) ? SHIFT : EXEC;
                end
                EXEC: begin
                    Wdata    <= res[WIDTH-1:0];
                    store_ex <= res[WIDTH];
                    if (valid) cflag <= res[WIDTH];
                    done     <= 1'b1;
                    state    <= DONE;
                end
                SHIFT: begin
                    a_r   <= sh_val;
                    cnt_r <= cnt_r - 1'b1;
                    if (cnt_r == SCW'(1)) begin
                        Wdata    <= sh_val;
                        store_ex <= sh_out;
                        cflag    <= sh_out;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, start, sel;
    logic [3:0]  kind, sc;
    logic [2:0]  fn3;
    logic [1:0]  fn2;
    logic [15:0] rd1, rd2, cst;
    logic        busy8, done8, ex8, cf8, busy16, done16, ex16, cf16;
    logic [7:0]  w8;
    logic [15:0] w16;
    logic        busy, done, ex, cf;
    logic [15:0] w;
    int checks = 0, errors = 0;
    int lat, bc, ndone;
    logic [15:0] wc;
    logic exc, cfc;

    alu_seq #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .start(start & ~sel), .kind(kind), .fn3(fn3), .fn2(fn2),
        .rd1(rd1[7:0]), .rd2(rd2[7:0]), ._const(cst[7:0]), .sc(sc[2:0]),
        .busy(busy8), .done(done8), .Wdata(w8), .store_ex(ex8), .cflag(cf8));
    alu_seq #(.WIDTH(16)) d16 (
        .clk(clk), .rst(rst), .start(start & sel), .kind(kind), .fn3(fn3), .fn2(fn2),
        .rd1(rd1), .rd2(rd2), ._const(cst), .sc(sc),
        .busy(busy16), .done(done16), .Wdata(w16), .store_ex(ex16), .cflag(cf16));

    assign busy = sel ? busy16 : busy8;
    assign done = sel ? done16 : done8;
    assign ex   = sel ? ex16 : ex8;
    assign cf   = sel ? cf16 : cf8;
    assign w    = sel ? w16 : {8'h00, w8};

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic issue(input logic s16, input logic [3:0] k, input logic [2:0] f3,
                         input logic [1:0] f2, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [3:0] s);
        sel = s16; kind = k; fn3 = f3; fn2 = f2; rd1 = a; rd2 = b; cst = c; sc = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int l0);
        lat = l0; bc = 0;
        while (!done && lat < 40) begin
            bc += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        bc += int'(busy);
        wc = w; exc = ex; cfc = cf;
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 16'(busy), 16'h0);
        chk({tag, "_idle_done"}, 16'(done), 16'h0);
    endtask

    task automatic run(input string tag, input logic s16, input logic [3:0] k,
                       input logic [2:0] f3, input logic [1:0] f2, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c, input logic [3:0] s,
                       input int el, input logic [15:0] ew, input logic eex, input logic ecf);
        issue(s16, k, f3, f2, a, b, c, s);
        wait_done(tag, 1);
        chk({tag, "_lat"}, 16'(lat), 16'(el));
        chk({tag, "_busycyc"}, 16'(bc), 16'(el));
        chk({tag, "_w"}, wc, ew);
        chk({tag, "_ex"}, 16'(exc), 16'(eex));
        chk({tag, "_cf"}, 16'(cfc), 16'(ecf));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; kind = '0; fn3 = '0; fn2 = '0;
        rd1 = '0; rd2 = '0; cst = '0; sc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_w", w, 16'h0);
        chk("rst_ex", 16'(ex), 16'h0);
        chk("rst_cf", 16'(cf), 16'h0);
        rst = 1'b0;
        run("add",  0, 4'b0000, 3'b000, 2'b00, 16'hF0, 16'h20, 16'h00, 4'd0, 2, 16'h10, 1, 1);
        run("adc",  0, 4'b0000, 3'b001, 2'b00, 16'h01, 16'h01, 16'h00, 4'd0, 2, 16'h03, 0, 0);
        run("subi", 0, 4'b0001, 3'b010, 2'b00, 16'h10, 16'h55, 16'h20, 4'd0, 2, 16'hF0, 1, 1);
        run("nand", 0, 4'b0000, 3'b111, 2'b00, 16'hFF, 16'h0F, 16'h00, 4'd0, 2, 16'hF0, 0, 0);
        run("shr3", 0, 4'b0010, 3'b000, 2'b01, 16'h05, 16'h00, 16'h00, 4'd3, 4, 16'h00, 1, 1);
        run("shr0", 0, 4'b0010, 3'b000, 2'b01, 16'h05, 16'h00, 16'h00, 4'd0, 2, 16'h05, 0, 0);
        run("add2", 0, 4'b0000, 3'b000, 2'b00, 16'hF0, 16'h20, 16'h00, 4'd0, 2, 16'h10, 1, 1);
        run("sbb",  0, 4'b0000, 3'b011, 2'b00, 16'h20, 16'h10, 16'h00, 4'd0, 2, 16'h0F, 0, 0);
        run("add3", 0, 4'b0000, 3'b000, 2'b00, 16'hF0, 16'h20, 16'h00, 4'd0, 2, 16'h10, 1, 1);
        run("inv",  0, 4'b1111, 3'b000, 2'b00, 16'hAA, 16'hBB, 16'h00, 4'd0, 2, 16'h00, 0, 1);
        issue(0, 4'b0010, 3'b000, 2'b00, 16'h00FF, 16'h0, 16'h0, 4'd7);
        repeat (2) @(posedge clk);
        #1;
        kind = 4'b0000; rd1 = 16'h01; rd2 = 16'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 4);
        chk("busy_start_lat", 16'(lat), 16'd8);
        chk("busy_start_w", wc, 16'h80);
        chk("busy_start_ex", 16'(exc), 16'h1);
        ndone = 0;
        repeat (6) begin
            ndone += int'(done);
            @(posedge clk); #1;
        end
        chk("busy_start_extra_done", 16'(ndone), 16'h0);
        chk("busy_start_cf", 16'(cf), 16'h1);
        issue(0, 4'b0010, 3'b000, 2'b00, 16'h00FF, 16'h0, 16'h0, 4'd7);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_done", 16'(done), 16'h0);
        chk("midrst_w", w, 16'h0);
        chk("midrst_ex", 16'(ex), 16'h0);
        chk("midrst_cf", 16'(cf), 16'h0);
        ndone = 0;
        repeat (10) begin
            ndone += int'(done) + int'(busy);
            @(posedge clk); #1;
        end
        chk("midrst_no_done", 16'(ndone), 16'h0);
        run("rol16", 1, 4'b0010, 3'b000, 2'b10, 16'h8000, 16'h0, 16'h0, 4'd15, 16, 16'h4000, 0, 0);
        run("shl16", 1, 4'b0010, 3'b000, 2'b00, 16'h0001, 16'h0, 16'h0, 4'd15, 16, 16'h8000, 0, 0);
        run("sub16", 1, 4'b0000, 3'b010, 2'b00, 16'h0000, 16'h0001, 16'h0, 4'd0, 2, 16'hFFFF, 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
